// File: rtl/lsu_if.sv
// Request/response and memory-bus bundle for the load/store unit.
// The master side is the LSU; the slave side is its requester plus the memory.
interface lsu_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 ren;
   logic                 wen;
   logic [1:0]           size;
   logic                 memory_read_signed;
   logic [ADDR_W-1:0]    addr;
   logic [XLEN-1:0]      wdata;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      memory_read_wd;
   logic                 misalign;
   logic                 mem_req_valid;
   logic                 mem_req_ready;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [XLEN-1:0]      mem_wdata;
   logic [XLEN/8-1:0]    mem_wstrb;
   logic                 mem_resp_valid;
   logic [XLEN-1:0]      mem_rdata;

   modport master (
      input  in_valid, ren, wen, size, memory_read_signed, addr, wdata,
             out_ready, mem_req_ready, mem_resp_valid, mem_rdata,
      output in_ready, out_valid, memory_read_wd, misalign,
             mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output in_valid, ren, wen, size, memory_read_signed, addr, wdata,
             out_ready, mem_req_ready, mem_resp_valid, mem_rdata,
      input  in_ready, out_valid, memory_read_wd, misalign,
             mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, lane alignment of store
// data and strobes, and extraction plus sign/zero extension of load data.
module lsu_ctrl #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic  clk,
   input  logic  rst,
   lsu_if.master bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              state, state_d;
   logic                ren_p0, wen_p0, sgn_p0;
   logic [1:0]          size_p0;
   logic [ADDR_W-1:0]   addr_p0;
   logic [XLEN-1:0]     wdata_p0;
   logic [XLEN-1:0]     rd_p1, rd_d;
   logic                mis_p1, mis_d;
   logic                accept, rd_en;
   logic [OFF_W-1:0]    off;

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
      case (sz)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = a[0];
         2'd2:    misaligned = |a[1:0];
         default: misaligned = (XLEN == 32) || (|a[2:0]);
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                   input logic [1:0] sz, input logic sgn,
                                                   input logic [OFF_W-1:0] o);
      logic [XLEN-1:0]    sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      sh = raw >> {o, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      w  = sh[31:0];
      case (sz)
         2'd0: if (sgn) load_extend = XLEN'(b); else load_extend = XLEN'(sh[7:0]);
         2'd1: if (sgn) load_extend = XLEN'(h); else load_extend = XLEN'(sh[15:0]);
         2'd2: if (sgn) load_extend = XLEN'(w); else load_extend = XLEN'(sh[31:0]);
         default: load_extend = sh;
      endcase
   endfunction

   function automatic logic [NB-1:0] lane_strobe(input logic [1:0] sz, input logic [OFF_W-1:0] o);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
      lane_strobe = m << o;
   endfunction

   assign off = addr_p0[OFF_W-1:0];

   always_comb begin
      state_d           = state;
      accept            = 1'b0;
      rd_en             = 1'b0;
      rd_d              = '0;
      mis_d             = 1'b0;
      bus.in_ready      = 1'b0;
      bus.out_valid     = 1'b0;
      bus.mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = !rst;
            if (bus.in_valid && !rst) begin
               accept = 1'b1;
               // Faults and no-ops complete immediately without touching memory.
               if ((bus.ren || bus.wen) && misaligned(bus.size, bus.addr[2:0])) begin
                  state_d = DONE;
                  mis_d   = 1'b1;
                  rd_en   = 1'b1;
               end else if (!bus.ren && !bus.wen) begin
                  state_d = DONE;
                  rd_en   = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.mem_resp_valid) begin
               state_d = DONE;
               rd_en   = 1'b1;
               if (ren_p0 && !wen_p0) rd_d = load_extend(bus.mem_rdata, size_p0, sgn_p0, off);
            end
         end
         default: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Request capture stage
   always_ff @(posedge clk) begin
      if (accept) begin
         ren_p0   <= bus.ren;
         wen_p0   <= bus.wen;
         sgn_p0   <= bus.memory_read_signed;
         size_p0  <= bus.size;
         addr_p0  <= bus.addr;
         wdata_p0 <= bus.wdata;
      end
   end

   // Result stage, held through DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_p1  <= '0;
         mis_p1 <= 1'b0;
      end else if (rd_en) begin
         rd_p1  <= rd_d;
         mis_p1 <= mis_d;
      end
   end

   assign bus.mem_we         = wen_p0;
   assign bus.mem_addr       = {addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign bus.mem_wdata      = wen_p0 ? (wdata_p0 << {off, 3'b000}) : '0;
   assign bus.mem_wstrb      = wen_p0 ? lane_strobe(size_p0, off) : '0;
   assign bus.memory_read_wd = rd_p1;
   assign bus.misalign       = mis_p1;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl at XLEN=32 and XLEN=64 with queue-based result scoreboards.
module tb_lsu_ctrl;
   typedef struct packed {
      logic [63:0] rd;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   exp_t q32[$];
   exp_t q64[$];
   exp_t e32, e64;
   logic        auto32 = 1'b1;
   logic        force32 = 1'b0;
   logic [31:0] rd32 = '0;
   logic [63:0] rd64 = '0;

   lsu_if #(.XLEN(32), .ADDR_W(32)) a ();
   lsu_if #(.XLEN(64), .ADDR_W(32)) b ();

   lsu_ctrl #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(a.master));
   lsu_ctrl #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b.master));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Memory responders: one response cycle after each accepted request
   always begin
      @(negedge clk);
      if ((auto32 && a.mem_req_valid && a.mem_req_ready) || force32) begin
         @(posedge clk); #1;
         a.mem_resp_valid = 1'b1;
         a.mem_rdata      = rd32;
         @(posedge clk); #1;
         a.mem_resp_valid = 1'b0;
      end
   end

   always begin
      @(negedge clk);
      if (b.mem_req_valid && b.mem_req_ready) begin
         @(posedge clk); #1;
         b.mem_resp_valid = 1'b1;
         b.mem_rdata      = rd64;
         @(posedge clk); #1;
         b.mem_resp_valid = 1'b0;
      end
   end

   // Result monitors
   always @(negedge clk) begin
      if (!rst && a.out_valid && a.out_ready) begin
         if (q32.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL x32_unexpected_out: got rd=%h, expected no output", a.memory_read_wd);
         end else begin
            e32 = q32.pop_front();
            chk("x32_rd", 64'(a.memory_read_wd), e32.rd);
            chk("x32_mis", 64'(a.misalign), 64'(e32.mis));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b.out_valid && b.out_ready) begin
         if (q64.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL x64_unexpected_out: got rd=%h, expected no output", b.memory_read_wd);
         end else begin
            e64 = q64.pop_front();
            chk("x64_rd", b.memory_read_wd, e64.rd);
            chk("x64_mis", 64'(b.misalign), 64'(e64.mis));
         end
      end
   end

   task automatic issue32(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd);
      int n = 0;
      @(posedge clk); #1;
      a.ren = r; a.wen = w; a.size = sz; a.memory_read_signed = sg; a.addr = ad; a.wdata = wd;
      a.in_valid = 1'b1;
      @(negedge clk);
      while (!a.in_ready && n < 50) begin n++; @(negedge clk); end
      if (!a.in_ready) begin nvec++; nerr++; $display("FAIL x32_accept_timeout: got in_ready=0, expected 1"); end
      @(posedge clk); #1;
      a.in_valid = 1'b0;
   endtask

   task automatic issue64(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [63:0] wd);
      int n = 0;
      @(posedge clk); #1;
      b.ren = r; b.wen = w; b.size = sz; b.memory_read_signed = sg; b.addr = ad; b.wdata = wd;
      b.in_valid = 1'b1;
      @(negedge clk);
      while (!b.in_ready && n < 50) begin n++; @(negedge clk); end
      if (!b.in_ready) begin nvec++; nerr++; $display("FAIL x64_accept_timeout: got in_ready=0, expected 1"); end
      @(posedge clk); #1;
      b.in_valid = 1'b0;
   endtask

   task automatic wait_idle32();
      int n = 0;
      @(negedge clk);
      while (!a.in_ready && n < 50) begin n++; @(negedge clk); end
      if (!a.in_ready) begin nvec++; nerr++; $display("FAIL x32_idle_timeout: got in_ready=0, expected 1"); end
   endtask

   task automatic wait_idle64();
      int n = 0;
      @(negedge clk);
      while (!b.in_ready && n < 50) begin n++; @(negedge clk); end
      if (!b.in_ready) begin nvec++; nerr++; $display("FAIL x64_idle_timeout: got in_ready=0, expected 1"); end
   endtask

   task automatic load32(input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                         input logic [31:0] rd, input logic [31:0] exp, input logic mis);
      wait_idle32();
      rd32 = rd;
      q32.push_back('{rd: 64'(exp), mis: mis});
      issue32(1'b1, 1'b0, sz, sg, ad, 32'h0);
   endtask

   task automatic load64(input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                         input logic [63:0] rd, input logic [63:0] exp);
      wait_idle64();
      rd64 = rd;
      q64.push_back('{rd: exp, mis: 1'b0});
      issue64(1'b1, 1'b0, sz, sg, ad, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      a.in_valid = 0; a.ren = 0; a.wen = 0; a.size = 0; a.memory_read_signed = 0;
      a.addr = 0; a.wdata = 0; a.out_ready = 1; a.mem_req_ready = 1;
      a.mem_resp_valid = 0; a.mem_rdata = 0;
      b.in_valid = 0; b.ren = 0; b.wen = 0; b.size = 0; b.memory_read_signed = 0;
      b.addr = 0; b.wdata = 0; b.out_ready = 1; b.mem_req_ready = 1;
      b.mem_resp_valid = 0; b.mem_rdata = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(a.in_ready), 64'h0);
      chk("rst_out_valid", 64'(a.out_valid), 64'h0);
      chk("rst_mem_req_valid", 64'(a.mem_req_valid), 64'h0);
      chk("rst_misalign", 64'(a.misalign), 64'h0);
      chk("rst_rd", 64'(a.memory_read_wd), 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(a.in_ready), 64'h1);

      // Signed byte load, zero-wait latency
      rd32 = 32'h80FF1234;
      q32.push_back('{rd: 64'hFFFFFF80, mis: 1'b0});
      issue32(1'b1, 1'b0, 2'd0, 1'b1, 32'h80000003, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) chk("lat_req_valid", 64'(a.mem_req_valid), 64'h1);
         chk("lat_out_valid", 64'(a.out_valid), (k == 3) ? 64'h1 : 64'h0);
      end

      // Half-word store lane placement
      wait_idle32();
      q32.push_back('{rd: 64'h0, mis: 1'b0});
      issue32(1'b0, 1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000BEEF);
      @(negedge clk);
      chk("st_addr", 64'(a.mem_addr), 64'h80000000);
      chk("st_wdata", 64'(a.mem_wdata), 64'hBEEF0000);
      chk("st_wstrb", 64'(a.mem_wstrb), 64'hC);
      chk("st_we", 64'(a.mem_we), 64'h1);

      // Misaligned word load faults without a memory request
      wait_idle32();
      q32.push_back('{rd: 64'h0, mis: 1'b1});
      issue32(1'b1, 1'b0, 2'd2, 1'b0, 32'h80000001, 32'h0);
      @(negedge clk);
      chk("mis_out_valid", 64'(a.out_valid), 64'h1);
      chk("mis_req_valid", 64'(a.mem_req_valid), 64'h0);

      // Backpressure on both the memory request and the result
      wait_idle32();
      a.out_ready = 1'b0; a.mem_req_ready = 1'b0;
      rd32 = 32'h12345678;
      q32.push_back('{rd: 64'h12345678, mis: 1'b0});
      issue32(1'b1, 1'b0, 2'd2, 1'b0, 32'h10000004, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_req_valid", 64'(a.mem_req_valid), 64'h1);
         chk("stall_addr", 64'(a.mem_addr), 64'h10000004);
      end
      @(posedge clk); #1 a.mem_req_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!a.out_valid && n < 20) begin n++; @(negedge clk); end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         chk("hold_out_valid", 64'(a.out_valid), 64'h1);
         chk("hold_rd", 64'(a.memory_read_wd), 64'h12345678);
         chk("hold_in_ready", 64'(a.in_ready), 64'h0);
      end
      @(posedge clk); #1 a.out_ready = 1'b1;

      // No-op, dword fault at XLEN=32, load-and-store treated as store
      wait_idle32();
      q32.push_back('{rd: 64'h0, mis: 1'b0});
      issue32(1'b0, 1'b0, 2'd2, 1'b1, 32'h00000000, 32'h0);
      @(negedge clk);
      chk("noop_out_valid", 64'(a.out_valid), 64'h1);
      wait_idle32();
      q32.push_back('{rd: 64'h0, mis: 1'b1});
      issue32(1'b1, 1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0);
      wait_idle32();
      rd32 = 32'hFFFFFFFF;
      q32.push_back('{rd: 64'h0, mis: 1'b0});
      issue32(1'b1, 1'b1, 2'd2, 1'b0, 32'h00000020, 32'hCAFEF00D);
      @(negedge clk);
      chk("rw_we", 64'(a.mem_we), 64'h1);
      chk("rw_wstrb", 64'(a.mem_wstrb), 64'hF);
      chk("rw_wdata", 64'(a.mem_wdata), 64'hCAFEF00D);

      // Extraction vectors
      load32(2'd1, 1'b0, 32'h00000002, 32'h80FF1234, 32'h000080FF, 1'b0);
      load32(2'd1, 1'b1, 32'h00000002, 32'h80FF1234, 32'hFFFF80FF, 1'b0);
      load32(2'd1, 1'b1, 32'h00000000, 32'h80FF1234, 32'h00001234, 1'b0);
      load32(2'd0, 1'b0, 32'h00000001, 32'h80FF1234, 32'h00000012, 1'b0);
      load32(2'd2, 1'b1, 32'h00000008, 32'h80FF1234, 32'h80FF1234, 1'b0);

      // Reset while waiting for a response; late response must be ignored
      wait_idle32();
      auto32 = 1'b0;
      issue32(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0);
      @(negedge clk);
      chk("rw_req_valid", 64'(a.mem_req_valid), 64'h1);
      @(negedge clk);
      chk("wait_req_valid", 64'(a.mem_req_valid), 64'h0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_hold_in_ready", 64'(a.in_ready), 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_wait_in_ready", 64'(a.in_ready), 64'h1);
      chk("rst_wait_out_valid", 64'(a.out_valid), 64'h0);
      @(posedge clk); #1 force32 = 1'b1;
      @(negedge clk); #1 force32 = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_resp_out_valid", 64'(a.out_valid), 64'h0);
      chk("late_resp_in_ready", 64'(a.in_ready), 64'h1);
      auto32 = 1'b1;
      load32(2'd0, 1'b0, 32'h00000041, 32'h0000AB00, 32'h000000AB, 1'b0);

      // XLEN=64 vectors
      load64(2'd2, 1'b0, 32'h00001004, 64'hFEDCBA9876543210, 64'h00000000FEDCBA98);
      load64(2'd3, 1'b0, 32'h00001008, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210);
      load64(2'd2, 1'b1, 32'h00001000, 64'hFEDCBA9876543210, 64'h0000000076543210);
      load64(2'd0, 1'b1, 32'h00001007, 64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFE);
      wait_idle64();
      q64.push_back('{rd: 64'h0, mis: 1'b0});
      issue64(1'b0, 1'b1, 2'd0, 1'b0, 32'h00001005, 64'h00000000000000AA);
      @(negedge clk);
      chk("x64_st_addr", 64'(b.mem_addr), 64'h00001000);
      chk("x64_st_wdata", b.mem_wdata, 64'h0000AA0000000000);
      chk("x64_st_wstrb", 64'(b.mem_wstrb), 64'h20);

      wait_idle32();
      wait_idle64();
      chk("x32_queue_drained", 64'(q32.size()), 64'h0);
      chk("x64_queue_drained", 64'(q64.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
